// File: rtl/regfile_8x16.sv
// Eight-entry register file with two combinational read ports, one write port,
// write-through bypass, R0 hardwired to zero and a committed-write counter.
module regfile_8x16 #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             RegWrite,
  input  logic [2:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [2:0]       ReadReg1,
  input  logic [2:0]       ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic [15:0]      WriteCount
);

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_commit;

  // A write only lands outside reset and never into R0; bypass uses the same qualifier.
  assign wr_commit = RegWrite & ~Reset & (WriteReg != 3'd0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[WriteReg] <= WriteData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      WriteCount <= 16'd0;
    end else if (wr_commit) begin
      WriteCount <= WriteCount + 16'd1;
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (Reset || ReadReg1 == 3'd0) begin
      ReadData1 = '0;
    end else if (wr_commit && ReadReg1 == WriteReg) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs[ReadReg1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (Reset || ReadReg2 == 3'd0) begin
      ReadData2 = '0;
    end else if (wr_commit && ReadReg2 == WriteReg) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs[ReadReg2];
    end
  end

endmodule
